// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline control master that sits beside decode. It produces the hold (we)
// and bubble (clr) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. It handles load-use hazards, taken-branch flushes, I/D-cache miss
// freezes and HLT, and keeps saturating stall and flush performance counters.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   id_rs, id_rt               source registers of the instruction in ID
//   id_use_rs, id_use_rt       the ID instruction really reads rs / rt
//   ex_memRead, ex_rd          EX instruction is a load / its destination
//   ex_br_taken                EX redirects the PC this cycle
//   wb_hlt                     HLT has reached WB
//   icache_miss, icache_ready  I-cache miss level / fill-done pulse
//   dcache_miss, dcache_ready  D-cache miss level / fill-done pulse
//   pc_we                      PC update enable
//   ifid_we, ifid_clr          IF/ID hold / bubble
//   idex_we, idex_clr          ID/EX hold / bubble
//   exmem_we, memwb_we         back-end register enables
//   halted                     FSM is in HALT
//   stall_cnt, flush_cnt       saturating stall-cycle and flush counters
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memRead,
    input  logic [3:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             wb_hlt,
    input  logic             icache_miss,
    input  logic             icache_ready,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_clr,
    output logic             idex_we,
    output logic             idex_clr,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, DWAIT, IWAIT, HALT} state_t;

    state_t           state_reg, state_next;
    logic             redir_pend_reg, redir_pend_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic             flush_evt;
    logic             lu;
    logic             pc_we_c, ifid_we_c, ifid_clr_c, idex_we_c, idex_clr_c;
    logic             exmem_we_c, memwb_we_c;

    // Load-use: r0 is never a real dependency.
    assign lu = ex_memRead && (ex_rd != 4'd0) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    always_comb begin
        pc_we_c         = 1'b1;
        ifid_we_c       = 1'b1;
        ifid_clr_c      = 1'b0;
        idex_we_c       = 1'b1;
        idex_clr_c      = 1'b0;
        exmem_we_c      = 1'b1;
        memwb_we_c      = 1'b1;
        state_next      = state_reg;
        redir_pend_next = redir_pend_reg;
        flush_evt       = 1'b0;

        case (state_reg)
            RUN, DWAIT: begin
                // DWAIT stays frozen until the fill completes; the ready cycle
                // is then evaluated like RUN with the miss treated as gone.
                if (state_reg == DWAIT && !dcache_ready) begin
                    {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c} = '0;
                end else if (wb_hlt) begin
                    {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c} = '0;
                    state_next = HALT;
                end else if (state_reg == RUN && dcache_miss) begin
                    {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c} = '0;
                    state_next = DWAIT;
                end else if (ex_br_taken) begin
                    // Any coincident I-miss is on the wrong path; ignore it.
                    ifid_clr_c = 1'b1;
                    idex_clr_c = 1'b1;
                    flush_evt  = 1'b1;
                    state_next = RUN;
                end else if (lu) begin
                    pc_we_c    = 1'b0;
                    ifid_we_c  = 1'b0;
                    idex_clr_c = 1'b1;
                    state_next = RUN;
                end else if (icache_miss) begin
                    pc_we_c    = 1'b0;
                    ifid_clr_c = 1'b1;
                    state_next = IWAIT;
                end else begin
                    state_next = RUN;
                end
            end

            IWAIT: begin
                pc_we_c    = 1'b0;
                ifid_clr_c = 1'b1;
                if (wb_hlt) begin
                    {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c} = '0;
                    ifid_clr_c = 1'b0;
                    state_next = HALT;
                end else if (dcache_miss) begin
                    {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c} = '0;
                    ifid_clr_c = 1'b0;
                    state_next = DWAIT;
                    // A fill finishing now is lost (PC held) and refetched later,
                    // so a pending redirect no longer refers to it.
                    if (icache_ready)
                        redir_pend_next = 1'b0;
                end else if (ex_br_taken) begin
                    pc_we_c    = 1'b1;
                    idex_clr_c = 1'b1;
                    flush_evt  = 1'b1;
                    if (icache_ready) begin
                        redir_pend_next = 1'b0;
                        state_next      = RUN;
                    end else begin
                        redir_pend_next = 1'b1;
                    end
                end else if (lu) begin
                    // Hold PC and IF/ID; a fill completing now is simply
                    // refetched from RUN, where it now hits.
                    ifid_we_c  = 1'b0;
                    ifid_clr_c = 1'b0;
                    idex_clr_c = 1'b1;
                    if (icache_ready) begin
                        redir_pend_next = 1'b0;
                        state_next      = RUN;
                    end
                end else if (icache_ready) begin
                    // Fill word belongs to the old path if a redirect happened.
                    pc_we_c         = 1'b1;
                    ifid_clr_c      = redir_pend_reg;
                    redir_pend_next = 1'b0;
                    state_next      = RUN;
                end
            end

            default: begin // HALT
                {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c} = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            redir_pend_reg <= 1'b0;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            redir_pend_reg <= redir_pend_next;
            if (state_reg != HALT && !pc_we_c && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush_evt && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    // Everything is forced inactive while reset is asserted.
    assign pc_we     = rst_n & pc_we_c;
    assign ifid_we   = rst_n & ifid_we_c;
    assign ifid_clr  = rst_n & ifid_clr_c;
    assign idex_we   = rst_n & idex_we_c;
    assign idex_clr  = rst_n & idex_clr_c;
    assign exmem_we  = rst_n & exmem_we_c;
    assign memwb_we  = rst_n & memwb_we_c;
    assign halted    = rst_n & (state_reg == HALT);
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       id_rs = '0, id_rt = '0, ex_rd = '0;
    logic             id_use_rs = 0, id_use_rt = 0, ex_memRead = 0, ex_br_taken = 0;
    logic             wb_hlt = 0, icache_miss = 0, icache_ready = 0;
    logic             dcache_miss = 0, dcache_ready = 0;
    logic             pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we, memwb_we, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .wb_hlt(wb_hlt), .icache_miss(icache_miss), .icache_ready(icache_ready),
        .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_clr(ifid_clr),
        .idex_we(idex_we), .idex_clr(idex_clr), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we, memwb_we}
    localparam logic [6:0] O_DEF   = 7'b1101011;
    localparam logic [6:0] O_FRZ   = 7'b0000000;
    localparam logic [6:0] O_BR    = 7'b1111111;
    localparam logic [6:0] O_LU    = 7'b0001111;
    localparam logic [6:0] O_IMISS = 7'b0111011;
    localparam logic [6:0] O_IRDY_DROP = 7'b1111011;

    logic [6:0] outs;
    assign outs = {pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we, memwb_we};

    int errors = 0;
    int checks = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        string      name;
        logic       mr;
        logic [3:0] rd, rs, rt;
        logic       urs, urt, br, hlt, im, dm;
        logic [6:0] exp;
        logic [6:0] exp_nxt;
        int         st, fl;
        logic       hl;
    } vec_t;

    vec_t vecs[11];

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_memRead = 0; ex_rd = 0; ex_br_taken = 0; wb_hlt = 0;
        icache_miss = 0; icache_ready = 0; dcache_miss = 0; dcache_ready = 0;
    endtask

    // Push expectation when the cycle's stimulus is in place; pop and compare
    // when the outputs are sampled mid-cycle. Returns at posedge+1.
    task automatic cycle_check(input string nm, input logic [6:0] e);
        logic [6:0] ex, got;
        exp_q.push_back(e);
        @(negedge clk);
        got = outs;
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL %s: outs=%b expected=%b", nm, got, ex);
        end else
            $display("txn %s: outs=%b ok", nm, got);
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string nm, input int act, input int e);
        checks++;
        if (act != e) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", nm, act, e);
        end else
            $display("txn %s: %0d ok", nm, act);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_val("reset_outs", {24'd0, outs, halted}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name        mr rd rs rt urs urt br hlt im dm exp      nxt      st fl hl
        vecs[0]  = '{"idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,   O_DEF,   0, 0, 0};
        vecs[1]  = '{"lu_rs",     1, 3, 3, 0, 1, 0, 0, 0, 0, 0, O_LU,    O_DEF,   1, 0, 0};
        vecs[2]  = '{"lu_rd0",    1, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_DEF,   O_DEF,   0, 0, 0};
        vecs[3]  = '{"lu_rt",     1, 5, 2, 5, 1, 1, 0, 0, 0, 0, O_LU,    O_DEF,   1, 0, 0};
        vecs[4]  = '{"lu_nouse",  1, 3, 3, 3, 0, 0, 0, 0, 0, 0, O_DEF,   O_DEF,   0, 0, 0};
        vecs[5]  = '{"br_imiss",  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, O_BR,    O_DEF,   0, 1, 0};
        vecs[6]  = '{"imiss",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IMISS, O_IMISS, 1, 0, 0};
        vecs[7]  = '{"dmiss_br",  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, O_FRZ,   O_FRZ,   1, 0, 0};
        vecs[8]  = '{"hlt_dmiss", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FRZ,   O_FRZ,   1, 0, 1};
        vecs[9]  = '{"br_lu",     1, 4, 4, 0, 1, 0, 1, 0, 0, 0, O_BR,    O_DEF,   0, 1, 0};
        vecs[10] = '{"lu_imiss",  1, 7, 0, 7, 0, 1, 0, 0, 1, 0, O_LU,    O_DEF,   1, 0, 0};

        idle();
        @(posedge clk);
        #1;
        do_reset();
        check_val("rst_stall", stall_cnt, 0);
        check_val("rst_flush", flush_cnt, 0);

        // Single-event vectors from RUN, plus the follow-up cycle to expose the next state.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            ex_memRead = vecs[i].mr; ex_rd = vecs[i].rd; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_use_rs = vecs[i].urs; id_use_rt = vecs[i].urt; ex_br_taken = vecs[i].br;
            wb_hlt = vecs[i].hlt; icache_miss = vecs[i].im; dcache_miss = vecs[i].dm;
            cycle_check(vecs[i].name, vecs[i].exp);
            check_val({vecs[i].name, "_stall"}, stall_cnt, vecs[i].st);
            check_val({vecs[i].name, "_flush"}, flush_cnt, vecs[i].fl);
            check_val({vecs[i].name, "_halted"}, halted, vecs[i].hl);
            idle();
            cycle_check({vecs[i].name, "_next"}, vecs[i].exp_nxt);
        end

        // D-cache miss for 5 cycles, released by the ready pulse.
        do_reset();
        dcache_miss = 1;
        for (int c = 0; c < 5; c++) cycle_check("dmiss_freeze", O_FRZ);
        dcache_miss = 0; dcache_ready = 1;
        cycle_check("dmiss_ready", O_DEF);
        dcache_ready = 0;
        cycle_check("dmiss_after", O_DEF);
        check_val("dmiss_stall", stall_cnt, 5);

        // I-miss, branch during IWAIT, then the fill word is discarded.
        do_reset();
        icache_miss = 1;
        cycle_check("iw_enter", O_IMISS);
        ex_br_taken = 1;
        cycle_check("iw_branch", O_BR);
        ex_br_taken = 0;
        cycle_check("iw_wait", O_IMISS);
        icache_ready = 1;
        cycle_check("iw_ready_drop", O_IRDY_DROP);
        idle();
        cycle_check("iw_back_run", O_DEF);
        check_val("iw_flush", flush_cnt, 1);
        check_val("iw_stall", stall_cnt, 2);

        // Plain I-miss: ready cycle keeps the fill word.
        do_reset();
        icache_miss = 1;
        cycle_check("im_enter", O_IMISS);
        icache_ready = 1;
        cycle_check("im_ready", O_DEF);
        idle();
        cycle_check("im_run", O_DEF);

        // Reset in the middle of a redirected miss clears the pending redirect.
        do_reset();
        icache_miss = 1;
        cycle_check("rm_enter", O_IMISS);
        ex_br_taken = 1;
        cycle_check("rm_branch", O_BR);
        ex_br_taken = 0;
        do_reset();
        cycle_check("rm_reenter", O_IMISS);
        icache_ready = 1;
        cycle_check("rm_ready_keep", O_DEF);
        idle();

        // HALT is terminal until reset; counters hold.
        do_reset();
        wb_hlt = 1;
        cycle_check("hlt_cycle", O_FRZ);
        wb_hlt = 0; ex_br_taken = 1; icache_miss = 1;
        for (int c = 0; c < 4; c++) cycle_check("hlt_frozen", O_FRZ);
        check_val("hlt_halted", halted, 1);
        check_val("hlt_stall_hold", stall_cnt, 1);
        check_val("hlt_flush_hold", flush_cnt, 0);
        idle();
        do_reset();
        check_val("hlt_rst_halted", halted, 0);
        check_val("hlt_rst_stall", stall_cnt, 0);
        cycle_check("hlt_rst_run", O_DEF);

        // Counter saturation at 2^CNT_W-1.
        do_reset();
        ex_memRead = 1; ex_rd = 9; id_rs = 9; id_use_rs = 1;
        for (int c = 0; c < 20; c++) cycle_check("sat_lu", O_LU);
        check_val("sat_stall", stall_cnt, 15);
        idle();
        ex_br_taken = 1;
        for (int c = 0; c < 20; c++) cycle_check("sat_br", O_BR);
        check_val("sat_flush", flush_cnt, 15);
        check_val("sat_stall_hold", stall_cnt, 15);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
